// File: rtl/axi_wr_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// axi_wr_arbiter_2to1
//
// Round-robin arbiter that lets two AXI4-Lite write masters share one
// write-only AXI4-Lite slave. Only one write is in flight at a time. The
// read channels do not pass through this block.
//
// Ports
//   AXI_ACLK, AXI_ARESETN          clock, asynchronous active-low reset
//   S_AW* / S_W* / S_B*            two requester ports, packed; requester n
//                                  occupies slice n of each vector
//                                  (S_BRESP: bits [2n+1:2n])
//   M_AW* / M_W* / M_B*            single master port towards the slave
//
// Flow: IDLE picks a requester (round-robin on a tie) -> XFER forwards AW and
// W, each completing independently -> RESP holds B routing until the response
// handshake. When the response handshake lands in the same cycle as the last
// AW/W handshake, RESP is skipped.
// ---------------------------------------------------------------------------
module axi_wr_arbiter_2to1 #(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32
) (
    input  logic                        AXI_ACLK,
    input  logic                        AXI_ARESETN,

    input  logic [2*AXI_AWIDTH-1:0]     S_AWADDR,
    input  logic [1:0]                  S_AWVALID,
    output logic [1:0]                  S_AWREADY,
    input  logic [2*AXI_DWIDTH-1:0]     S_WDATA,
    input  logic [2*(AXI_DWIDTH/8)-1:0] S_WSTRB,
    input  logic [1:0]                  S_WVALID,
    output logic [1:0]                  S_WREADY,
    output logic [3:0]                  S_BRESP,
    output logic [1:0]                  S_BVALID,
    input  logic [1:0]                  S_BREADY,

    output logic [AXI_AWIDTH-1:0]       M_AWADDR,
    output logic                        M_AWVALID,
    input  logic                        M_AWREADY,
    output logic [AXI_DWIDTH-1:0]       M_WDATA,
    output logic [AXI_DWIDTH/8-1:0]     M_WSTRB,
    output logic                        M_WVALID,
    input  logic                        M_WREADY,
    input  logic [1:0]                  M_BRESP,
    input  logic                        M_BVALID,
    output logic                        M_BREADY
);

    localparam int SW = AXI_DWIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   grant;       // index of the requester currently being served
    logic   last_grant;  // requester served most recently; loses the next tie
    logic   aw_done;
    logic   w_done;

    logic       in_xfer;
    logic       in_resp;
    logic       aw_hs;
    logic       w_hs;
    logic       aw_all;
    logic       w_all;
    logic       b_route;
    logic       b_hs;
    logic [1:0] req;

    // aw_all/w_all count a handshake completing this cycle, so B routing can
    // open in the same cycle as the final AW or W handshake.
    always_comb begin
        in_xfer = (state == XFER);
        in_resp = (state == RESP);
        aw_hs   = in_xfer & S_AWVALID[grant] & ~aw_done & M_AWREADY;
        w_hs    = in_xfer & S_WVALID[grant]  & ~w_done  & M_WREADY;
        aw_all  = aw_done | aw_hs;
        w_all   = w_done  | w_hs;
        b_route = in_resp | (in_xfer & aw_all & w_all);
        b_hs    = b_route & M_BVALID & S_BREADY[grant];
        req     = S_AWVALID & S_WVALID;
    end

    // Outputs depend only on registered state plus pass-through channel
    // signals. The reset state is IDLE, so every output is 0 while reset is
    // asserted.
    always_comb begin
        M_AWADDR  = '0;
        M_WDATA   = '0;
        M_WSTRB   = '0;
        M_AWVALID = 1'b0;
        M_WVALID  = 1'b0;
        M_BREADY  = 1'b0;
        S_AWREADY = 2'b00;
        S_WREADY  = 2'b00;
        S_BVALID  = 2'b00;
        S_BRESP   = 4'h0;
        if (in_xfer) begin
            M_AWADDR  = grant ? S_AWADDR[2*AXI_AWIDTH-1:AXI_AWIDTH] : S_AWADDR[AXI_AWIDTH-1:0];
            M_WDATA   = grant ? S_WDATA[2*AXI_DWIDTH-1:AXI_DWIDTH]  : S_WDATA[AXI_DWIDTH-1:0];
            M_WSTRB   = grant ? S_WSTRB[2*SW-1:SW]                  : S_WSTRB[SW-1:0];
            M_AWVALID = S_AWVALID[grant] & ~aw_done;
            M_WVALID  = S_WVALID[grant]  & ~w_done;
            S_AWREADY[grant] = M_AWREADY & ~aw_done;
            S_WREADY[grant]  = M_WREADY  & ~w_done;
        end
        if (b_route) begin
            M_BREADY        = S_BREADY[grant];
            S_BVALID[grant] = M_BVALID;
            if (grant) begin
                S_BRESP[3:2] = M_BRESP;
            end else begin
                S_BRESP[1:0] = M_BRESP;
            end
        end
    end

    // last_grant resets to 1 so requester 0 wins the first tie after reset.
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (req != 2'b00) begin
                        grant <= (req == 2'b11) ? ~last_grant : req[1];
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (aw_all && w_all) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (b_hs) begin
                            last_grant <= grant;
                            state      <= IDLE;
                        end else begin
                            state <= RESP;
                        end
                    end else begin
                        aw_done <= aw_all;
                        w_done  <= w_all;
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
